// File: rtl/reg_dump_if.sv
// Bundle between the register-dump engine, its start/status owner and the byte sink.
// No latency of its own; pure wiring.
// The tx_valid/tx_ready pair carries the backpressure from the sink.
interface reg_dump_if #(
    parameter int WORD_SIZE = 32
);
    logic                 start;
    logic [4:0]           debug_reg;
    logic [WORD_SIZE-1:0] debug_reg_out;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 busy;
    logic                 done;

    modport master (
        input  start, debug_reg_out, tx_ready,
        output debug_reg, tx_data, tx_valid, busy, done
    );

    modport slave (
        output start, debug_reg_out, tx_ready,
        input  debug_reg, tx_data, tx_valid, busy, done
    );
endinterface

// File: rtl/reg_dump.sv
// Serialises registers 0..NUM_REGS-1 from the debug read port as A5 + LSB-first bytes.
// First byte valid one cycle after start; one FETCH bubble per register, done pulse at end.
// Stalls in SYNC/SEND while tx_ready is low, holding tx_valid/tx_data; start ignored while busy.
module reg_dump #(
    parameter int WORD_SIZE = 32,
    parameter int NUM_REGS  = 32
) (
    input  logic       clk,
    input  logic       rst,
    reg_dump_if.master bus
);
    localparam int BYTES = WORD_SIZE / 8;
    localparam int RW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [RW-1:0] LAST_REG  = RW'(NUM_REGS - 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(BYTES - 1);
    localparam logic [7:0]    SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {IDLE, SYNC, FETCH, SEND, DONE} state_t;

    state_t               state;
    logic [RW-1:0]        reg_idx;
    logic [BW-1:0]        byte_idx;
    logic [WORD_SIZE-1:0] shift;
    logic [WORD_SIZE-1:0] shift_nxt;
    logic [RW-1:0]        reg_nxt;
    logic                 hs;

    assign hs        = bus.tx_valid && bus.tx_ready;
    assign shift_nxt = shift >> 8;
    assign reg_nxt   = reg_idx + RW'(1);

    // tx_data always mirrors shift[7:0] in SEND, so it is loaded one step ahead of the shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            reg_idx       <= '0;
            byte_idx      <= '0;
            shift         <= '0;
            bus.tx_valid  <= 1'b0;
            bus.tx_data   <= 8'h00;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.debug_reg <= 5'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state        <= SYNC;
                        reg_idx      <= '0;
                        bus.tx_valid <= 1'b1;
                        bus.tx_data  <= SYNC_BYTE;
                        bus.busy     <= 1'b1;
                    end
                end
                SYNC: begin
                    if (hs) begin
                        state         <= FETCH;
                        bus.tx_valid  <= 1'b0;
                        bus.debug_reg <= 5'(reg_idx);
                    end
                end
                FETCH: begin
                    shift        <= bus.debug_reg_out;
                    byte_idx     <= '0;
                    bus.tx_data  <= bus.debug_reg_out[7:0];
                    bus.tx_valid <= 1'b1;
                    state        <= SEND;
                end
                SEND: begin
                    if (hs) begin
                        shift       <= shift_nxt;
                        bus.tx_data <= shift_nxt[7:0];
                        if (byte_idx == LAST_BYTE) begin
                            byte_idx     <= '0;
                            bus.tx_valid <= 1'b0;
                            if (reg_idx == LAST_REG) begin
                                state         <= DONE;
                                bus.done      <= 1'b1;
                                bus.debug_reg <= 5'd0;
                            end else begin
                                reg_idx       <= reg_nxt;
                                bus.debug_reg <= 5'(reg_nxt);
                                state         <= FETCH;
                            end
                        end else begin
                            byte_idx <= byte_idx + BW'(1);
                        end
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_dump.sv
// Bench for reg_dump: register-file model, randomized sink backpressure, byte-frame scoreboard.
module tb_reg_dump;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_dump_if #(.WORD_SIZE(32)) bus ();
    reg_dump #(.WORD_SIZE(32), .NUM_REGS(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] regs [32];
    assign bus.debug_reg_out = regs[bus.debug_reg];

    int n_checks = 0;
    int n_fail   = 0;
    int rdy_mode = 0;           // 0: always ready, 1: 50% random, 2: never ready
    int n_done   = 0;
    byte unsigned got[$];
    byte unsigned exp_q[$];
    logic       hold_vld = 1'b0;
    logic [7:0] hold_dat = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Sink: drive tx_ready just after each rising edge.
    initial begin
        bus.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1)      bus.tx_ready = 1'($urandom_range(0, 1));
            else if (rdy_mode == 2) bus.tx_ready = 1'b0;
            else                    bus.tx_ready = 1'b1;
        end
    end

    // Monitor: collect accepted bytes, count done pulses, check stability under stall.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                hold_vld = 1'b0;
            end else begin
                if (hold_vld) begin
                    chk("stall_valid", 32'(bus.tx_valid), 32'd1);
                    chk("stall_data", 32'(bus.tx_data), 32'(hold_dat));
                end
                if (bus.tx_valid && bus.tx_ready) got.push_back(bus.tx_data);
                if (bus.done) n_done++;
                hold_vld = bus.tx_valid && !bus.tx_ready;
                hold_dat = bus.tx_data;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_model();
        for (int k = 0; k < 32; k++) regs[k] = 32'(k) * 32'h0101_0101;
        regs[2] = 32'h0000_7ffc;
        regs[3] = 32'h0000_1000;
    endtask

    // Expected frame: sync byte, then each register's bytes from the low end upward.
    task automatic build_exp();
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int k = 0; k < 32; k++)
            for (int b = 0; b < 4; b++)
                exp_q.push_back(8'((regs[k] / (32'd1 << (8 * b))) % 256));
    endtask

    task automatic start_dump();
        got.delete();
        n_done = 0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic compare_frame(input string tag);
        logic [31:0] obs;
        chk({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = (i < got.size()) ? 32'(got[i]) : 32'hDEAD_BEEF;
            chk($sformatf("%s_byte%0d", tag, i), obs, 32'(exp_q[i]));
        end
        chk({tag, "_done_count"}, 32'(n_done), 32'd1);
    endtask

    task automatic finish_frame(input string tag, input bit repulse);
        int c = 0;
        while (bus.busy !== 1'b0 && c < 3000) begin
            bus.start = (repulse && (c == 30 || c == 90 || c == 150)) ? 1'b1 : 1'b0;
            step();
            c++;
        end
        bus.start = 1'b0;
        chk({tag, "_timeout"}, 32'(c < 3000), 32'd1);
        step();
        compare_frame(tag);
    endtask

    task automatic wait_bytes(input string tag, input int n);
        int c = 0;
        while (got.size() < n && c < 3000) begin
            step();
            c++;
        end
        chk({tag, "_wait"}, 32'(got.size() >= n), 32'd1);
    endtask

    initial begin
        int cnt;
        bus.start = 1'b0;
        load_model();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_data", 32'(bus.tx_data), 32'h00);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_dbg", 32'(bus.debug_reg), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) step();
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_valid", 32'(bus.tx_valid), 32'd0);

        // Scenario: reference registers, sink always ready, latency and done timing.
        load_model();
        build_exp();
        rdy_mode = 0;
        start_dump();
        @(negedge clk);
        chk("first_valid", 32'(bus.tx_valid), 32'd1);
        chk("first_data", 32'(bus.tx_data), 32'hA5);
        chk("first_busy", 32'(bus.busy), 32'd1);
        cnt = 1;
        while (bus.done !== 1'b1 && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        chk("done_cycle", 32'(cnt), 32'd162);
        chk("done_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        chk("done_pulse", 32'(bus.done), 32'd0);
        chk("after_busy", 32'(bus.busy), 32'd0);
        chk("after_dbg", 32'(bus.debug_reg), 32'd0);
        chk("after_valid", 32'(bus.tx_valid), 32'd0);
        step();
        compare_frame("ref");

        // Scenario: random backpressure.
        rdy_mode = 1;
        start_dump();
        finish_frame("rand_rdy", 1'b0);

        // Scenario: start re-pulsed mid-dump.
        rdy_mode = 0;
        start_dump();
        finish_frame("repulse", 1'b1);

        // Scenario: reset after byte 40, then a clean frame.
        start_dump();
        wait_bytes("abort", 40);
        rst = 1'b0;
        #1;
        chk("abort_valid", 32'(bus.tx_valid), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_dbg", 32'(bus.debug_reg), 32'd0);
        chk("abort_data", 32'(bus.tx_data), 32'h00);
        repeat (3) step();
        chk("abort_no_done", 32'(n_done), 32'd0);
        chk("abort_bytes", 32'(got.size()), 32'd40);
        rst = 1'b1;
        repeat (4) step();
        chk("abort_idle", 32'(bus.busy), 32'd0);
        start_dump();
        finish_frame("post_abort", 1'b0);

        // Scenario: x5 overwritten while its bytes are on the wire.
        load_model();
        regs[5] = 32'h1111_1111;
        build_exp();
        rdy_mode = 1;
        start_dump();
        wait_bytes("snap", 22);
        regs[5] = 32'h2222_2222;
        finish_frame("snapshot", 1'b0);

        // Scenario: sink stalled for 100 cycles in SYNC.
        load_model();
        build_exp();
        rdy_mode = 2;
        bus.tx_ready = 1'b0;
        start_dump();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("sync_valid", 32'(bus.tx_valid), 32'd1);
            chk("sync_data", 32'(bus.tx_data), 32'hA5);
            chk("sync_busy", 32'(bus.busy), 32'd1);
            chk("sync_bytes", 32'(got.size()), 32'd0);
        end
        step();
        rdy_mode = 0;
        finish_frame("sync_stall", 1'b0);

        // Scenario: random register contents under random backpressure.
        for (int k = 0; k < 32; k++) regs[k] = $urandom;
        build_exp();
        rdy_mode = 1;
        start_dump();
        finish_frame("rand_regs", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
